// File: rtl/branch_resolve_unit.sv
// Resolves control flow in EX: detects mispredicts and redirects fetch in the same
// cycle, and queues resolved outcomes for the branch predictor to consume.
module branch_resolve_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        ex_bcond,
  input  logic [31:0] ex_pc_plus_imm,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] id_pc,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        ex_stall,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic [1:0]  upd_kind,
  output logic [31:0] cf_count,
  output logic [31:0] mispred_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  kind;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cf_cnt_q, cf_cnt_d;
  logic [31:0]   mp_cnt_q, mp_cnt_d;

  logic        cf, full, resolve, mispredict, push, pop;
  logic [31:0] pc_plus4, jalr_target, actual_next;
  entry_t      push_entry;

  assign cf          = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
  assign pc_plus4    = ex_pc + 32'd4;
  assign jalr_target = ex_alu_result & ~32'd1;
  // Full comes from the registered count only, so a same-cycle pop never releases a stall.
  assign full        = (count_q == FULL_CNT);
  assign resolve     = cf & ~full;

  always_comb begin
    actual_next = pc_plus4;
    push_entry  = '0;
    if (ex_is_jal) begin
      actual_next = ex_pc_plus_imm;
      push_entry  = '{pc: ex_pc, target: ex_pc_plus_imm, taken: 1'b1, kind: KIND_JAL};
    end else if (ex_is_jalr) begin
      actual_next = jalr_target;
      push_entry  = '{pc: ex_pc, target: jalr_target, taken: 1'b1, kind: KIND_JALR};
    end else begin
      actual_next = ex_bcond ? ex_pc_plus_imm : pc_plus4;
      push_entry  = '{pc: ex_pc, target: ex_pc_plus_imm, taken: ex_bcond, kind: KIND_BRANCH};
    end
  end

  assign mispredict  = resolve & (actual_next != id_pc);
  assign flush       = mispredict;
  assign redirect_pc = mispredict ? actual_next : pc_plus4;
  assign ex_stall    = cf & full;

  // Update port: an entry transfers on any rising edge where upd_valid and upd_ready
  // are both high; while upd_valid is high and upd_ready low the head is held stable.
  assign upd_valid  = (count_q != '0);
  assign pop        = upd_valid & upd_ready;
  assign push       = resolve;
  assign upd_pc     = mem_q[rd_ptr_q].pc;
  assign upd_target = mem_q[rd_ptr_q].target;
  assign upd_taken  = mem_q[rd_ptr_q].taken;
  assign upd_kind   = mem_q[rd_ptr_q].kind;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    cf_cnt_d = (resolve && cf_cnt_q != '1) ? cf_cnt_q + 32'd1 : cf_cnt_q;
    mp_cnt_d = (mispredict && mp_cnt_q != '1) ? mp_cnt_q + 32'd1 : mp_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cf_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cf_cnt_q <= cf_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and count alone define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign cf_count      = cf_cnt_q;
  assign mispred_count = mp_cnt_q;

endmodule
